// File: rtl/mcu_ram_arb_pkg.sv
// mcu_ram_arb_pkg
// Shared types and defaults for the two-master RAM arbiter.
//   owner_e : last-granted requester (NONE / A / B)
//   AW_DEF  : default word-address width of the shared RAM
//   DW_DEF  : default data width of the shared RAM
package mcu_ram_arb_pkg;

  localparam int AW_DEF = 11;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

endpackage : mcu_ram_arb_pkg

// File: rtl/mcu_ram_rr_pick.sv
// mcu_ram_rr_pick
// Combinational grant decision for two requesters sharing one RAM port.
// Ports:
//   a_req, b_req   : requests from A (CPU) and B (DMA/loader)
//   a_lock, b_lock : owner asks to keep the port for back-to-back accesses
//   owner          : last-granted requester
//   burst_cnt      : consecutive grants to the owner while the other waits
//   pick_a, pick_b : one-hot (or zero) grant decision
module mcu_ram_rr_pick
  import mcu_ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_lock,
  input  logic       b_lock,
  input  owner_e     owner,
  input  logic [7:0] burst_cnt,
  output logic       pick_a,
  output logic       pick_b
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  logic below_max_s;
  logic hold_s;

  assign below_max_s = (burst_cnt < MAX_BURST_C);

  // The owner keeps the port under contention only while it locks and its
  // burst budget is not used up; otherwise the non-owner gets its turn.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    hold_s = 1'b0;
    case ({a_req, b_req})
      2'b10: pick_a = 1'b1;
      2'b01: pick_b = 1'b1;
      2'b11: begin
        case (owner)
          OWN_A: begin
            hold_s = a_lock & below_max_s;
            if (hold_s) pick_a = 1'b1;
            else        pick_b = 1'b1;
          end
          OWN_B: begin
            hold_s = b_lock & below_max_s;
            if (hold_s) pick_b = 1'b1;
            else        pick_a = 1'b1;
          end
          default: pick_a = 1'b1;
        endcase
      end
      default: begin
        pick_a = 1'b0;
        pick_b = 1'b0;
      end
    endcase
  end

endmodule : mcu_ram_rr_pick

// File: rtl/mcu_ram_arb.sv
// mcu_ram_arb
// Arbitrates a single-port RAM (bypass read, data one cycle after issue)
// between requester A (CPU) and requester B (DMA/loader).
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   {a,b}_req/we/addr/wdata   : request, write enable, word address, write data
//   {a,b}_lock                : keep ownership for back-to-back accesses
//   {a,b}_gnt                 : combinational grant, access taken this edge
//   {a,b}_rvalid/rdata        : read response one cycle after a granted read
//   ram_ce/oce/wre/reset      : RAM controls
//   ram_ad, ram_din, ram_dout : RAM address, write data, read data
module mcu_ram_arb
  import mcu_ram_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          a_lock,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic          b_lock,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic          ram_wre,
  output logic          ram_reset,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  owner_e     owner_r,   owner_nxt_s;
  logic [7:0] burst_r,   burst_nxt_s;
  logic       tag_vld_r, tag_b_r;
  logic       pick_a_s,  pick_b_s;
  logic       a_gnt_s,   b_gnt_s;

  mcu_ram_rr_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .a_req     (a_req),
    .b_req     (b_req),
    .a_lock    (a_lock),
    .b_lock    (b_lock),
    .owner     (owner_r),
    .burst_cnt (burst_r),
    .pick_a    (pick_a_s),
    .pick_b    (pick_b_s)
  );

  // Grants stay combinational but are held off while reset is asserted.
  assign a_gnt_s = pick_a_s & reset_n;
  assign b_gnt_s = pick_b_s & reset_n;
  assign a_gnt   = a_gnt_s;
  assign b_gnt   = b_gnt_s;

  // RAM port mux from the granted requester; all zero when idle.
  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (a_gnt_s) begin
      ram_ce  = 1'b1;
      ram_wre = a_we;
      ram_ad  = a_addr;
      ram_din = a_wdata;
    end else if (b_gnt_s) begin
      ram_ce  = 1'b1;
      ram_wre = b_we;
      ram_ad  = b_addr;
      ram_din = b_wdata;
    end else begin
      ram_ce  = 1'b0;
    end
  end

  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

  // Next owner and burst count: count only grants made under contention,
  // restart at 1 when ownership changes, saturate at 8'hFF.
  always_comb begin
    owner_nxt_s = owner_r;
    burst_nxt_s = burst_r;
    if (a_gnt_s) begin
      owner_nxt_s = OWN_A;
      if (!b_req)                   burst_nxt_s = 8'd0;
      else if (owner_r != OWN_A)    burst_nxt_s = 8'd1;
      else if (burst_r != 8'hFF)    burst_nxt_s = burst_r + 8'd1;
      else                          burst_nxt_s = burst_r;
    end else if (b_gnt_s) begin
      owner_nxt_s = OWN_B;
      if (!a_req)                   burst_nxt_s = 8'd0;
      else if (owner_r != OWN_B)    burst_nxt_s = 8'd1;
      else if (burst_r != 8'hFF)    burst_nxt_s = burst_r + 8'd1;
      else                          burst_nxt_s = burst_r;
    end else begin
      // No grant means nobody contends for the port.
      burst_nxt_s = 8'd0;
    end
  end

  // Owner and burst counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_r <= OWN_NONE;
      burst_r <= 8'd0;
    end else begin
      owner_r <= owner_nxt_s;
      burst_r <= burst_nxt_s;
    end
  end

  // Single read tag: the RAM returns data one cycle after issue, so one
  // in-flight read is all that can exist and a new grant overwrites it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_r <= 1'b0;
      tag_b_r   <= 1'b0;
    end else begin
      tag_vld_r <= (a_gnt_s & ~a_we) | (b_gnt_s & ~b_we);
      tag_b_r   <= b_gnt_s;
    end
  end

  assign a_rvalid = tag_vld_r & ~tag_b_r;
  assign b_rvalid = tag_vld_r &  tag_b_r;
  assign a_rdata  = a_rvalid ? ram_dout : '0;
  assign b_rdata  = b_rvalid ? ram_dout : '0;

endmodule : mcu_ram_arb

// File: tb/tb_mcu_ram_arb.sv
// tb_mcu_ram_arb
// Directed bench for mcu_ram_arb with a behavioural bypass-read RAM.
// Inputs change on the falling edge; grants are sampled 1 ns later and read
// responses are sampled on the falling edge after the granting rising edge.
module tb_mcu_ram_arb;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr, ram_ad;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din;
  logic [DW-1:0] ram_dout;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic          ram_ce, ram_oce, ram_wre, ram_reset;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  mcu_ram_arb #(.AW(AW), .DW(DW), .MAX_BURST(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_lock    (a_lock),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_lock    (b_lock),
    .a_gnt     (a_gnt),
    .b_gnt     (b_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_wre   (ram_wre),
    .ram_reset (ram_reset),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on the edge, read data available the next cycle.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         ram_dout    <= mem[ram_ad];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    mem[0] = 16'h91C0;
    mem[1] = 16'h8009;
    mem[2] = 16'h1908;
    ram_dout = 16'h0000;
    idle_all();

    // Reset: grants suppressed even with both requesting; ties checked.
    reset_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    #1;
    chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("rst_ce",    {31'd0, ram_ce}, 32'd0);
    chk("rst_rv",    {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("oce_tie",   {31'd0, ram_oce}, 32'd1);
    chk("rreset_tie",{31'd0, ram_reset}, 32'd0);
    @(negedge clk); @(negedge clk);
    idle_all();
    reset_n = 1'b1;
    @(negedge clk);

    // A-only reads of 0,1,2 back to back.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk("a36_rv",    {31'd0, a_rvalid}, 32'd1);
        chk("a36_rdata", {16'd0, a_rdata},
            (i == 1) ? 32'h91C0 : (i == 2) ? 32'h8009 : 32'h1908);
      end
      if (i < 3) begin
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'(i);
        #1;
        chk("a36_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
        chk("a36_ad",  {21'd0, ram_ad}, 32'(i));
        chk("a36_wre", {30'd0, ram_ce, ram_wre}, 32'd2);
      end else begin
        idle_all();
        #1;
        chk("idle_ce", {31'd0, ram_ce}, 32'd0);
        chk("idle_ad", {21'd0, ram_ad}, 32'd0);
      end
      @(negedge clk);
    end
    chk("a36_rv_off", {31'd0, a_rvalid}, 32'd0);
    chk("a36_rd_off", {16'd0, a_rdata}, 32'd0);

    // Owner A: A reads 0x000 while B writes 0x7FF -> B first, then A.
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h000;
    b_req = 1'b1; b_we = 1'b1; b_addr = 11'h7FF; b_wdata = 16'hBEEF;
    #1;
    chk("s41_gnt1", {30'd0, a_gnt, b_gnt}, 32'd1);
    chk("s41_wre",  {30'd0, ram_ce, ram_wre}, 32'd3);
    chk("s41_ad",   {21'd0, ram_ad}, 32'h7FF);
    chk("s41_din",  {16'd0, ram_din}, 32'hBEEF);
    @(negedge clk);
    chk("s41_brv",  {31'd0, b_rvalid}, 32'd0);
    b_req = 1'b0; b_we = 1'b0;
    #1;
    chk("s41_gnt2", {30'd0, a_gnt, b_gnt}, 32'd2);
    @(negedge clk);
    chk("s41_arv",  {30'd0, a_rvalid, b_rvalid}, 32'd2);
    chk("s41_rd",   {16'd0, a_rdata}, 32'h91C0);

    // A reads back the word B wrote.
    a_addr = 11'h7FF;
    #1;
    chk("s39_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    @(negedge clk);
    chk("s39_rv",  {30'd0, a_rvalid, b_rvalid}, 32'd2);
    chk("s39_rd",  {16'd0, a_rdata}, 32'hBEEF);
    idle_all();
    @(negedge clk);

    // Both request continuously without lock, owner A -> B,A,B,A,B,A.
    a_req = 1'b1; a_addr = 11'h001;
    b_req = 1'b1; b_addr = 11'h002;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        chk("s37_rv", {30'd0, a_rvalid, b_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd2);
        chk("s37_rd", {16'd0, (i % 2 == 1) ? b_rdata : a_rdata},
            (i % 2 == 1) ? 32'h1908 : 32'h8009);
      end
      #1;
      chk("s37_gnt", {30'd0, a_gnt, b_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    idle_all();
    @(negedge clk);

    // B locks with A waiting, owner A -> 8 B grants, then A.
    a_req = 1'b1; a_addr = 11'h001;
    b_req = 1'b1; b_addr = 11'h002; b_lock = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        chk("s38_brv", {31'd0, b_rvalid}, 32'd1);
        chk("s38_brd", {16'd0, b_rdata}, 32'h1908);
      end
      #1;
      chk("s38_gnt", {30'd0, a_gnt, b_gnt}, (i < 8) ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    chk("s38_arv", {30'd0, a_rvalid, b_rvalid}, 32'd2);
    idle_all();
    @(negedge clk);

    // Reset right after a read is taken: no rvalid; owner back to NONE.
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h000;
    #1;
    chk("s40_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("s40_rv",   {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("s40_gnt0", {30'd0, a_gnt, b_gnt}, 32'd0);
    @(negedge clk);
    chk("s40_rv2",  {30'd0, a_rvalid, b_rvalid}, 32'd0);
    b_req = 1'b1;
    reset_n = 1'b1;
    #1;
    chk("s40_rv3",  {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("s40_first",{30'd0, a_gnt, b_gnt}, 32'd2);
    @(negedge clk);
    idle_all();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mcu_ram_arb
